avalon_st_fifo: RTL and testbench
=================================

# avalon_st_fifo

Parametrised Avalon-ST packet FIFO that sits between any two `avalon_if` endpoints in the tick-to-trade path, such as the feed decoder and the order-book stage. It buffers beats carrying `data`, `empty`, `startofpacket`, `endofpacket` and `error`, with ready-latency-0 handshakes on both sides. It runs in one of two modes: cut-through, or store-and-forward. Store-and-forward releases only complete packets, can drop errored packets, and reports occupancy, packet count and drop statistics.

## Interface
- DATA_WIDTH, 64, width of `data`.
- EMPTY_WIDTH, 3, width of `empty`.
- DEPTH, 16, number of beat entries; power of two, minimum 4.
- STORE_FWD, 0, operating mode.
  - 0 = cut-through.
  - 1 = store-and-forward.
- DROP_ON_ERROR, 1, applies only when STORE_FWD=1. When set, a packet whose eop beat has `error`=1 is discarded.
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- in_valid, in_startofpacket, in_endofpacket, in_error  in  1  sink side.
- in_data  in  DATA_WIDTH  sink data.
- in_empty  in  EMPTY_WIDTH  sink empty.
- in_ready  out  1  sink backpressure.
- out_valid, out_startofpacket, out_endofpacket, out_error  out  1  source side.
- out_data  out  DATA_WIDTH  source data.
- out_empty  out  EMPTY_WIDTH  source empty.
- out_ready  in  1  downstream backpressure.
- level  out  $clog2(DEPTH)+1  committed beats available to the source.
- pkt_count  out  $clog2(DEPTH)+1  complete packets held (STORE_FWD=1), otherwise 0.
- drop_cnt  out  16  dropped packets and orphan beats; saturates at 16'hFFFF.

## Operation
- **Beat encoding.** A stored beat is {sop, eop, error, empty, data}. The source presents the head entry show-ahead.
- **Handshakes.** A sink accept occurs when in_valid && in_ready. A source pop occurs when out_valid && out_ready. `out_*` fields are don't-care when out_valid=0.
- **in_ready** = !full, computed from registered pointers only. There is no combinational path from out_ready to in_ready.
- **Cut-through (STORE_FWD=0).**
  - Framing is not checked; beats pass unmodified.
  - out_valid = level != 0.
  - pkt_count = 0.
  - drop_cnt stays 0.
- **Store-and-forward (STORE_FWD=1).**
  - Pointers: wr_ptr (speculative), commit_ptr and rd_ptr.
  - out_valid = (rd_ptr != commit_ptr).
  - level = commit_ptr - rd_ptr.
- **Input FSM (STORE_FWD=1), states IDLE, IN_PKT, DISCARD:**
  - IDLE, accept with sop=1, eop=1: write the beat, then commit (or drop, see below); stay in IDLE.
  - IDLE, accept with sop=1, eop=0: write the beat and go to IN_PKT.
  - IDLE, accept with sop=0: orphan beat. It is not written; drop_cnt+1.
  - IN_PKT, accept with sop=1: rewind wr_ptr to commit_ptr and drop_cnt+1, then treat the beat as a new sop from IDLE.
  - IN_PKT, accept with eop=1: write the beat. If DROP_ON_ERROR && error, rewind wr_ptr and drop_cnt+1. Otherwise commit_ptr is set to wr_ptr+1 and pkt_count+1. Go to IDLE.
  - IN_PKT, speculative fill reaches DEPTH while pkt_count=0 (the packet can never fit): rewind wr_ptr, drop_cnt+1, go to DISCARD.
  - DISCARD: in_ready=1; accepted beats are not written. An eop beat returns the FSM to IDLE.
- **Counting.** pkt_count decrements on popping an eop beat. A commit and a decrement in the same cycle net to no change.
- **Reset values.**
  - Pointers = 0; FSM = IDLE.
  - out_valid = 0, level = 0, pkt_count = 0, drop_cnt = 0.
  - in_ready = 1.
- **Reset mid-packet** discards all content, including any partial packet. No beat is emitted after reset deassertion until new input arrives.

## Timing
- Write-to-visible latency is 1 cycle. A beat accepted in cycle N drives out_valid in N+1 (cut-through). In store-and-forward, the eop commit in cycle N makes the whole packet visible in N+1.
- Throughput is 1 beat per clock on both sides simultaneously, with no bubbles.
- **Full.** in_ready=0 even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
- **Empty.** A push in the same cycle does not bypass to out_valid in that cycle.
- Pointers carry one extra wrap bit. Full/empty is determined by an MSB-differ / equal compare, and wrap-around is seamless.
- All outputs come directly from registers or from the storage read mux. There are no combinational input-to-output paths.

## Structure
- Add to t2t_pkg:
  - AVST_DATA_W=64.
  - AVST_EMPTY_W=3.
  - typedef enum t_avst_fifo_state {ST_IDLE, ST_IN_PKT, ST_DISCARD}.
- Sub-module avalon_st_fifo_mem holds the storage only: parametrised WIDTH/DEPTH, synchronous write, asynchronous read. The pointers, FSM and counters stay in the top.
- The top connects to an `avalon_if` instance at integration level through port-level wiring.

## Test plan
- **Cut-through streaming.** STORE_FWD=0, DEPTH=16, out_ready=1, 5-beat packet with data 1..5, empty=3 on eop -> identical beats appear one cycle later, with no bubbles.
- **Fill and backpressure.** STORE_FWD=0, out_ready=0, push 16 beats -> in_ready=0 and level=16. Then one pop -> in_ready returns to 1 the next cycle and level=15.
- **Store-and-forward commit.** STORE_FWD=1, 4-beat packet -> out_valid stays 0 until the cycle after eop is accepted; then pkt_count=1 and level=4.
- **Error drop.** STORE_FWD=1, DROP_ON_ERROR=1, 3-beat packet with error=1 on eop, followed by a good 2-beat packet -> only the 2 good beats emerge and drop_cnt=1.
- **Oversize and framing.** STORE_FWD=1, DEPTH=4:
  - A 6-beat packet -> dropped, DISCARD state, drop_cnt=1.
  - A following orphan beat (sop=0) -> drop_cnt=2.
  - A sop mid-packet -> drop_cnt=3, and the new packet is delivered intact.
- **Async reset mid-packet.** Assert reset with 2 committed and 1 partial beat stored -> out_valid=0, level=0 and in_ready=1 immediately. No stale beats after reset deasserts.

Source files
------------

// File: rtl/t2t_pkg.sv
// Shared constants and types for the tick-to-trade datapath.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package t2t_pkg;

  // Default Avalon-ST beat geometry between the feed decoder and the book stage.
  localparam int AVST_DATA_W  = 64;
  localparam int AVST_EMPTY_W = 3;

  // Input-side framing FSM of the store-and-forward packet FIFO.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PKT  = 2'd1,
    ST_DISCARD = 2'd2
  } t_avst_fifo_state;

  // Stored beat width: {sop, eop, error, empty, data}.
  function automatic int avst_beat_w(input int data_w, input int empty_w);
    return data_w + empty_w + 3;
  endfunction

endpackage

// File: rtl/avalon_st_fifo_mem.sv
// Beat storage for avalon_st_fifo: register array, synchronous write, asynchronous read.
// Latency: a write on edge N is readable right after edge N; reads are combinational.
// Backpressure: none; the owner decides when writes are legal.
//
// Ports:
//   clk      - storage clock
//   wr_en    - write strobe, wr_dat stored at wr_addr on the rising edge
//   wr_addr  - write index
//   wr_dat   - beat to store
//   rd_addr  - read index (head of queue)
//   rd_dat   - beat at rd_addr, show-ahead
module avalon_st_fifo_mem #(
  parameter int WIDTH = 70,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_dat
);

  // No reset on the array: validity is tracked entirely by the pointers.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/avalon_st_fifo.sv
// Avalon-ST packet FIFO, cut-through or store-and-forward (drops errored/oversize/malformed packets).
// Latency: 1 cycle write-to-visible; in store-and-forward a packet becomes visible the cycle after its eop.
// Backpressure: in_ready = !full from registered pointers only; a pop frees space the following cycle.
//
// Ports:
//   clk, reset               - single clock, asynchronous active-high reset
//   in_valid/in_ready        - sink handshake (ready latency 0)
//   in_data/in_empty         - sink payload
//   in_startofpacket, in_endofpacket, in_error - sink framing/status
//   out_valid/out_ready      - source handshake (ready latency 0), head shown ahead
//   out_data/out_empty       - source payload
//   out_startofpacket, out_endofpacket, out_error - source framing/status
//   level                    - committed beats available to the source
//   pkt_count                - complete packets held (store-and-forward only, else 0)
//   drop_cnt                 - dropped packets plus orphan beats, saturating
module avalon_st_fifo
  import t2t_pkg::*;
#(
  parameter int DATA_WIDTH    = AVST_DATA_W,
  parameter int EMPTY_WIDTH   = AVST_EMPTY_W,
  parameter int DEPTH         = 16,
  parameter int STORE_FWD     = 0,
  parameter int DROP_ON_ERROR = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     in_error,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [EMPTY_WIDTH-1:0]   in_empty,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic                     out_error,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [EMPTY_WIDTH-1:0]   out_empty,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_count,
  output logic [15:0]              drop_cnt
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          BW      = avst_beat_w(DATA_WIDTH, EMPTY_WIDTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one wrap bit above the index.
  // wr_ptr     : next free slot, may run ahead of commit_ptr inside a packet
  // commit_ptr : end of the beats the source may see
  // rd_ptr     : head of queue
  logic [AW:0]      wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_nxt, commit_ptr_nxt;
  logic [AW:0]      seg_start;
  t_avst_fifo_state state, state_nxt;

  logic             full;
  logic             accept;
  logic             pop;
  logic             wr_en;
  logic             commit;
  logic             pkt_dec;
  logic [1:0]       drop_inc;
  logic [16:0]      drop_sum;
  logic [BW-1:0]    wr_beat;
  logic [BW-1:0]    rd_beat;
  logic [AW:0]      pkt_cnt_q;
  logic [15:0]      drop_q;

  // ---------------------------------------------------------------------------
  // Flags and handshakes (registered state only, no input-to-output paths)
  // ---------------------------------------------------------------------------
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // DISCARD swallows beats without storing them, so it never needs to stall.
  assign in_ready  = ((STORE_FWD != 0) && (state == ST_DISCARD)) || !full;
  assign accept    = in_valid && in_ready;

  // In cut-through commit_ptr simply follows wr_ptr, so one compare serves both modes.
  assign out_valid = (rd_ptr != commit_ptr);
  assign pop       = out_valid && out_ready;
  assign level     = commit_ptr - rd_ptr;

  assign pkt_count = pkt_cnt_q;
  assign drop_cnt  = drop_q;

  // A sop arriving mid-packet restarts the packet on top of the abandoned
  // partial, so its beat lands at commit_ptr instead of wr_ptr.
  assign seg_start = ((state == ST_IN_PKT) && in_startofpacket) ? commit_ptr : wr_ptr;

  assign wr_beat = {in_startofpacket, in_endofpacket, in_error, in_empty, in_data};
  assign {out_startofpacket, out_endofpacket, out_error, out_empty, out_data} = rd_beat;

  assign pkt_dec = pop && out_endofpacket;

  // ---------------------------------------------------------------------------
  // Next-state: pointers, framing FSM, drop events
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    state_nxt      = state;
    wr_en          = 1'b0;
    commit         = 1'b0;
    drop_inc       = 2'd0;

    if (STORE_FWD == 0) begin
      if (accept) begin
        wr_en          = 1'b1;
        wr_ptr_nxt     = wr_ptr + PTR_ONE;
        commit_ptr_nxt = wr_ptr + PTR_ONE;
      end
    end else begin
      case (state)
        ST_IDLE, ST_IN_PKT: begin
          if (accept) begin
            if ((state == ST_IDLE) && !in_startofpacket) begin
              // Orphan beat outside any packet.
              drop_inc = 2'd1;
            end else begin
              if ((state == ST_IN_PKT) && in_startofpacket) begin
                drop_inc = 2'd1;  // abandoned partial packet
              end
              wr_en = 1'b1;
              if (in_endofpacket) begin
                state_nxt = ST_IDLE;
                if ((DROP_ON_ERROR != 0) && in_error) begin
                  wr_ptr_nxt = commit_ptr;
                  drop_inc   = drop_inc + 2'd1;
                end else begin
                  wr_ptr_nxt     = seg_start + PTR_ONE;
                  commit_ptr_nxt = seg_start + PTR_ONE;
                  commit         = 1'b1;
                end
              end else begin
                wr_ptr_nxt = seg_start + PTR_ONE;
                state_nxt  = ST_IN_PKT;
              end
            end
          end else if ((state == ST_IN_PKT) && full && (pkt_cnt_q == '0)) begin
            // The partial packet alone fills the buffer and nothing can drain
            // to make room: it can never complete, so throw it away.
            wr_ptr_nxt = commit_ptr;
            drop_inc   = 2'd1;
            state_nxt  = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (accept && in_endofpacket) begin
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      state      <= ST_IDLE;
      pkt_cnt_q  <= '0;
      drop_q     <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      state      <= state_nxt;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (STORE_FWD != 0) begin
        // Commit and eop pop in the same cycle cancel out.
        case ({commit, pkt_dec})
          2'b10:   pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
          2'b01:   pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
          default: pkt_cnt_q <= pkt_cnt_q;
        endcase
      end
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  avalon_st_fifo_mem #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (seg_start[AW-1:0]),
    .wr_dat  (wr_beat),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_dat  (rd_beat)
  );

endmodule

// File: tb/tb_avalon_st_fifo.sv
// Testbench for avalon_st_fifo: three instances (cut-through D16, store-and-forward D16, store-and-forward D4).
// Latency: n/a.
// Backpressure: driven randomly and in directed scenarios.
module tb_avalon_st_fifo;

  localparam int N = 3;
  localparam int SF  [N] = '{0, 1, 1};
  localparam int DEP [N] = '{16, 16, 4};

  typedef logic [69:0] beat_t;  // {sop, eop, err, empty[2:0], data[63:0]}

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid [N], in_sop [N], in_eop [N], in_err [N], out_ready [N];
  logic [63:0] in_data  [N];
  logic [2:0]  in_empty [N];
  logic        in_ready [N], out_valid [N], out_sop [N], out_eop [N], out_err [N];
  logic [63:0] out_data [N];
  logic [2:0]  out_empty[N];
  logic [4:0]  lvl [N], pc [N];
  logic [15:0] drop_cnt [N];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LW = $clog2(DEP[g]) + 1;
    logic [LW-1:0] lvl_w, pc_w;
    avalon_st_fifo #(
      .DATA_WIDTH(64), .EMPTY_WIDTH(3), .DEPTH(DEP[g]), .STORE_FWD(SF[g]), .DROP_ON_ERROR(1)
    ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[g]), .in_startofpacket(in_sop[g]), .in_endofpacket(in_eop[g]),
      .in_error(in_err[g]), .in_data(in_data[g]), .in_empty(in_empty[g]), .in_ready(in_ready[g]),
      .out_valid(out_valid[g]), .out_startofpacket(out_sop[g]), .out_endofpacket(out_eop[g]),
      .out_error(out_err[g]), .out_data(out_data[g]), .out_empty(out_empty[g]),
      .out_ready(out_ready[g]), .level(lvl_w), .pkt_count(pc_w), .drop_cnt(drop_cnt[g])
    );
    assign lvl[g] = 5'(lvl_w);
    assign pc[g]  = 5'(pc_w);
  end

  // ---------------------------------------------------------------------------
  // Reference model: committed-beat queue + partial-packet queue per instance
  // ---------------------------------------------------------------------------
  beat_t cq [N][$];
  beat_t pq [N][$];
  bit    m_inpkt [N];
  bit    m_disc  [N];
  int    m_drop  [N];

  function automatic int exp_pkt(int i);
    int    n;
    beat_t b;
    n = 0;
    for (int k = 0; k < cq[i].size(); k++) begin
      b = cq[i][k];
      if (b[68]) n++;
    end
    return (SF[i] != 0) ? n : 0;
  endfunction

  function automatic bit exp_rdy(int i);
    return m_disc[i] || ((cq[i].size() + pq[i].size()) < DEP[i]);
  endfunction

  task automatic model_step(int i);
    bit    acc, pp;
    int    pk;
    beat_t b;
    pk  = exp_pkt(i);
    acc = in_valid[i] && exp_rdy(i);
    pp  = (cq[i].size() != 0) && out_ready[i];
    b   = {in_sop[i], in_eop[i], in_err[i], in_empty[i], in_data[i]};
    if (pp) void'(cq[i].pop_front());
    if (SF[i] == 0) begin
      if (acc) cq[i].push_back(b);
    end else if (m_disc[i]) begin
      if (acc && b[68]) m_disc[i] = 1'b0;
    end else if (acc) begin
      if (!m_inpkt[i] && !b[69]) begin
        m_drop[i]++;
      end else begin
        if (m_inpkt[i] && b[69]) begin
          m_drop[i]++;
          pq[i].delete();
        end
        pq[i].push_back(b);
        if (b[68]) begin
          if (b[67]) m_drop[i]++;
          else for (int k = 0; k < pq[i].size(); k++) cq[i].push_back(pq[i][k]);
          pq[i].delete();
          m_inpkt[i] = 1'b0;
        end else begin
          m_inpkt[i] = 1'b1;
        end
      end
    end else if (m_inpkt[i] && pk == 0 && pq[i].size() == DEP[i]) begin
      m_drop[i]++;
      pq[i].delete();
      m_inpkt[i] = 1'b0;
      m_disc[i]  = 1'b1;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        cq[i].delete();
        pq[i].delete();
        m_inpkt[i] = 1'b0;
        m_disc[i]  = 1'b0;
        m_drop[i]  = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) model_step(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(int i, bit v, bit s, bit e, bit er, logic [2:0] em, logic [63:0] d);
    in_valid[i] = v;  in_sop[i] = s;  in_eop[i] = e;
    in_err[i]   = er; in_empty[i] = em; in_data[i] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      drive(i, 0, 0, 0, 0, 3'd0, 64'd0);
      out_ready[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Holds one beat until accepted (in_ready is registered, so its value at the
  // negedge is the value seen at the following posedge).
  task automatic send(int i, bit s, bit e, bit er, logic [63:0] d);
    bit acc;
    int t;
    t = 0;
    drive(i, 1, s, e, er, 3'd0, d);
    do begin
      acc = in_ready[i];
      @(negedge clk);
      t++;
    end while (!acc && t < 50);
    drive(i, 0, 0, 0, 0, 3'd0, 64'd0);
    n_cmp++;
    if (!acc) begin n_err++; $display("FAIL send_timeout[%0d] beat %0d never accepted", i, d); end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (out_valid[i] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d] got %b exp 0", i, out_valid[i]); end
      n_cmp++; if (lvl[i] !== 5'd0) begin n_err++; $display("FAIL reset_level[%0d] got %0d exp 0", i, lvl[i]); end
      n_cmp++; if (pc[i] !== 5'd0) begin n_err++; $display("FAIL reset_pkt_count[%0d] got %0d exp 0", i, pc[i]); end
      n_cmp++; if (drop_cnt[i] !== 16'd0) begin n_err++; $display("FAIL reset_drop_cnt[%0d] got %0d exp 0", i, drop_cnt[i]); end
      n_cmp++; if (in_ready[i] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d] got %b exp 1", i, in_ready[i]); end
    end
  endtask

  task automatic test_cut_through();
    do_reset();
    out_ready[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1, k == 1, k == 5, 0, (k == 5) ? 3'd3 : 3'd0, 64'(k));
      if (k == 1) begin
        #1;
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL ct_no_bypass got %b exp 0", out_valid[0]); end
      end
      @(negedge clk);
      n_cmp++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL ct_valid beat %0d got %b exp 1", k, out_valid[0]); end
      n_cmp++; if (out_data[0] !== 64'(k)) begin n_err++; $display("FAIL ct_data got %0d exp %0d", out_data[0], k); end
      n_cmp++; if ({out_sop[0], out_eop[0]} !== {k == 1, k == 5}) begin n_err++; $display("FAIL ct_framing beat %0d got %b%b", k, out_sop[0], out_eop[0]); end
      n_cmp++; if (out_empty[0] !== ((k == 5) ? 3'd3 : 3'd0)) begin n_err++; $display("FAIL ct_empty beat %0d got %0d", k, out_empty[0]); end
    end
    drive(0, 0, 0, 0, 0, 3'd0, 64'd0);
    @(negedge clk);
    n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL ct_drained got %b exp 0", out_valid[0]); end
  endtask

  task automatic test_fill_backpressure();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 0, 0, 0, 3'd0, 64'(k));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 3'd0, 64'd0);
    n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %b exp 0", in_ready[0]); end
    n_cmp++; if (lvl[0] !== 5'd16) begin n_err++; $display("FAIL full_level got %0d exp 16", lvl[0]); end
    // Pop while offering a beat: the beat must be refused, space shows next cycle.
    out_ready[0] = 1'b1;
    drive(0, 1, 0, 0, 0, 3'd0, 64'hDEAD);
    @(negedge clk);
    out_ready[0] = 1'b0;
    drive(0, 0, 0, 0, 0, 3'd0, 64'd0);
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL pop_in_ready got %b exp 1", in_ready[0]); end
    n_cmp++; if (lvl[0] !== 5'd15) begin n_err++; $display("FAIL pop_level got %0d exp 15", lvl[0]); end
    n_cmp++; if (out_data[0] !== 64'd1) begin n_err++; $display("FAIL pop_head got %0d exp 1", out_data[0]); end
  endtask

  task automatic test_sf_commit();
    do_reset();
    out_ready[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, k == 1, k == 4, 0, 3'd0, 64'(100 + k));
      @(negedge clk);
      if (k < 4) begin
        n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL sf_hold beat %0d got %b exp 0", k, out_valid[1]); end
      end
    end
    drive(1, 0, 0, 0, 0, 3'd0, 64'd0);
    n_cmp++; if (out_valid[1] !== 1'b1) begin n_err++; $display("FAIL sf_visible got %b exp 1", out_valid[1]); end
    n_cmp++; if (pc[1] !== 5'd1) begin n_err++; $display("FAIL sf_pkt_count got %0d exp 1", pc[1]); end
    n_cmp++; if (lvl[1] !== 5'd4) begin n_err++; $display("FAIL sf_level got %0d exp 4", lvl[1]); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (out_data[1] !== 64'(100 + k)) begin n_err++; $display("FAIL sf_data got %0d exp %0d", out_data[1], 100 + k); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid[1] !== 1'b0 || pc[1] !== 5'd0) begin n_err++; $display("FAIL sf_drain valid %b pkt_count %0d exp 0 0", out_valid[1], pc[1]); end
  endtask

  task automatic test_error_drop();
    logic [63:0] sd [5] = '{64'd10, 64'd11, 64'd12, 64'd20, 64'd21};
    bit          ss [5] = '{1, 0, 0, 1, 0};
    bit          se [5] = '{0, 0, 1, 0, 1};
    bit          sr [5] = '{0, 0, 1, 0, 0};
    logic [63:0] got_d [8];
    int          got;
    got = 0;
    do_reset();
    out_ready[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid[1]) begin
        if (got < 8) got_d[got] = out_data[1];
        got++;
      end
      if (c < 5) drive(1, 1, ss[c], se[c], sr[c], 3'd0, sd[c]);
      else       drive(1, 0, 0, 0, 0, 3'd0, 64'd0);
      @(negedge clk);
    end
    n_cmp++; if (got !== 2) begin n_err++; $display("FAIL err_beats got %0d exp 2", got); end
    if (got >= 2) begin
      n_cmp++; if (got_d[0] !== 64'd20 || got_d[1] !== 64'd21) begin n_err++; $display("FAIL err_data got %0d,%0d exp 20,21", got_d[0], got_d[1]); end
    end
    n_cmp++; if (drop_cnt[1] !== 16'd1) begin n_err++; $display("FAIL err_drop_cnt got %0d exp 1", drop_cnt[1]); end
  endtask

  task automatic test_oversize_framing();
    do_reset();
    for (int k = 1; k <= 4; k++) send(2, k == 1, 0, 0, 64'(k));
    n_cmp++; if (in_ready[2] !== 1'b0 || lvl[2] !== 5'd0) begin n_err++; $display("FAIL ovs_full in_ready %b level %0d exp 0 0", in_ready[2], lvl[2]); end
    @(negedge clk);
    n_cmp++; if (in_ready[2] !== 1'b1 || drop_cnt[2] !== 16'd1) begin n_err++; $display("FAIL ovs_discard in_ready %b drop %0d exp 1 1", in_ready[2], drop_cnt[2]); end
    send(2, 0, 0, 0, 64'd5);
    send(2, 0, 1, 0, 64'd6);
    n_cmp++; if (drop_cnt[2] !== 16'd1 || lvl[2] !== 5'd0 || out_valid[2] !== 1'b0) begin n_err++; $display("FAIL ovs_after drop %0d level %0d valid %b exp 1 0 0", drop_cnt[2], lvl[2], out_valid[2]); end
    send(2, 0, 1, 0, 64'd7);
    n_cmp++; if (drop_cnt[2] !== 16'd2 || lvl[2] !== 5'd0) begin n_err++; $display("FAIL orphan drop %0d level %0d exp 2 0", drop_cnt[2], lvl[2]); end
    send(2, 1, 0, 0, 64'd8);
    send(2, 0, 0, 0, 64'd9);
    send(2, 1, 0, 0, 64'd10);
    send(2, 0, 1, 0, 64'd11);
    n_cmp++; if (drop_cnt[2] !== 16'd3) begin n_err++; $display("FAIL midsop_drop got %0d exp 3", drop_cnt[2]); end
    n_cmp++; if (lvl[2] !== 5'd2 || pc[2] !== 5'd1) begin n_err++; $display("FAIL midsop_level level %0d pkt %0d exp 2 1", lvl[2], pc[2]); end
    out_ready[2] = 1'b1;
    n_cmp++; if (out_data[2] !== 64'd10 || out_sop[2] !== 1'b1) begin n_err++; $display("FAIL midsop_b0 data %0d sop %b exp 10 1", out_data[2], out_sop[2]); end
    @(negedge clk);
    n_cmp++; if (out_data[2] !== 64'd11 || out_eop[2] !== 1'b1) begin n_err++; $display("FAIL midsop_b1 data %0d eop %b exp 11 1", out_data[2], out_eop[2]); end
    @(negedge clk);
    n_cmp++; if (out_valid[2] !== 1'b0) begin n_err++; $display("FAIL midsop_end got %b exp 0", out_valid[2]); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    send(1, 1, 0, 0, 64'd30);
    send(1, 0, 1, 0, 64'd31);
    send(1, 1, 0, 0, 64'd32);
    n_cmp++; if (lvl[1] !== 5'd2) begin n_err++; $display("FAIL rst_pre_level got %0d exp 2", lvl[1]); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid[1] !== 1'b0 || lvl[1] !== 5'd0 || in_ready[1] !== 1'b1) begin n_err++; $display("FAIL rst_async valid %b level %0d in_ready %b exp 0 0 1", out_valid[1], lvl[1], in_ready[1]); end
    @(negedge clk);
    reset = 1'b0;
    out_ready[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL rst_stale cycle %0d got %b exp 0", c, out_valid[1]); end
    end
  endtask

  task automatic test_random(int i, int cycles);
    beat_t ob, eb;
    int    rp;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      n_cmp++; if (in_ready[i] !== exp_rdy(i)) begin n_err++; $display("FAIL rnd_in_ready[%0d] cyc %0d got %b exp %b", i, c, in_ready[i], exp_rdy(i)); end
      n_cmp++; if (out_valid[i] !== (cq[i].size() != 0)) begin n_err++; $display("FAIL rnd_out_valid[%0d] cyc %0d got %b exp %b", i, c, out_valid[i], cq[i].size() != 0); end
      n_cmp++; if (lvl[i] !== 5'(cq[i].size())) begin n_err++; $display("FAIL rnd_level[%0d] cyc %0d got %0d exp %0d", i, c, lvl[i], cq[i].size()); end
      n_cmp++; if (pc[i] !== 5'(exp_pkt(i))) begin n_err++; $display("FAIL rnd_pkt_count[%0d] cyc %0d got %0d exp %0d", i, c, pc[i], exp_pkt(i)); end
      n_cmp++; if (drop_cnt[i] !== 16'(m_drop[i])) begin n_err++; $display("FAIL rnd_drop_cnt[%0d] cyc %0d got %0d exp %0d", i, c, drop_cnt[i], m_drop[i]); end
      if (cq[i].size() != 0) begin
        ob = {out_sop[i], out_eop[i], out_err[i], out_empty[i], out_data[i]};
        eb = cq[i][0];
        n_cmp++; if (ob !== eb) begin n_err++; $display("FAIL rnd_beat[%0d] cyc %0d got %h exp %h", i, c, ob, eb); end
      end
      rp = ((c / 100) % 2 == 1) ? 85 : 30;
      out_ready[i] = ($urandom_range(0, 99) < rp);
      drive(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), {$urandom, $urandom});
      @(negedge clk);
    end
    drive(i, 0, 0, 0, 0, 3'd0, 64'd0);
    out_ready[i] = 1'b0;
  endtask

  initial begin
    idle_all();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_cut_through();
    test_fill_backpressure();
    test_sf_commit();
    test_error_drop();
    test_oversize_framing();
    test_reset_mid_packet();
    for (int i = 0; i < N; i++) test_random(i, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
